adder_rr_scheduler: RTL and testbench

Shares one pipelined 128-bit adder (fixed latency, no stall, no reset) among N requesters. Requesters are granted in round-robin order, at most one issue per cycle. Each issue is tagged with its requester ID and carried alongside the adder pipeline so the sum returns to its owner. A flush handshake drains the pipeline before reconfiguration or power-down.

---
 rtl/adder_rr_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_adder_rr_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler that shares one external pipelined adder among N requesters,
// tagging each issue with its owner so the sum returns to the right requester.
module adder_rr_scheduler #(
    parameter int N       = 4,
    parameter int W       = 128,
    parameter int LAT     = 2,
    parameter int MAX_OUT = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N-1:0]         req_valid_i,
    output logic [N-1:0]         req_ready_o,
    input  logic [N*W-1:0]       req_a_i,
    input  logic [N*W-1:0]       req_b_i,
    output logic [W-1:0]         add_a_o,
    output logic [W-1:0]         add_b_o,
    input  logic [W-1:0]         add_sum_i,
    input  logic                 add_cout_i,
    output logic [N-1:0]         resp_valid_o,
    output logic [W-1:0]         resp_sum_o,
    output logic                 resp_cout_o,
    output logic [$clog2(N)-1:0] resp_id_o,
    input  logic                 flush_req_i,
    output logic                 flush_done_o,
    output logic                 busy_o
);

    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    out_cnt_q [N];
    logic [CW-1:0]    out_cnt_d [N];
    logic [W-1:0]     add_a_q, add_a_d;
    logic [W-1:0]     add_b_q, add_b_d;
    logic             flush_done_q, flush_done_d;

    // Stage 0 rides with the operand register; stages 1..LAT shadow the adder's internal registers.
    logic [LAT:0]     tag_vld_q;
    logic [IDW-1:0]   tag_id_q [LAT+1];

    logic [N-1:0]     resp_hit;
    logic [N-1:0]     eligible;
    logic [N-1:0]     grant;
    logic [IDW-1:0]   grant_id;
    logic [IDW:0]     scan_idx;
    logic             found;
    logic             grant_en;
    logic             accept;
    logic             pipe_empty;
    logic             pipe_drains;

    assign pipe_empty  = ~|tag_vld_q;
    assign pipe_drains = ~|tag_vld_q[LAT-1:0];
    assign grant_en    = (state_q != DRAIN) && !flush_req_i;
    assign accept      = |grant;

    always_comb begin
        resp_hit = '0;
        if (tag_vld_q[LAT]) begin
            resp_hit[tag_id_q[LAT]] = 1'b1;
        end
    end

    // A response retiring this cycle frees its slot immediately, so a saturated requester can re-issue in the same cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N; i++) begin
            eligible[i] = req_valid_i[i] && ((out_cnt_q[i] < CW'(MAX_OUT)) || resp_hit[i]);
        end
    end

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(N)) begin
                scan_idx = scan_idx - (IDW+1)'(N);
            end
            if (!found && grant_en && eligible[scan_idx[IDW-1:0]]) begin
                found    = 1'b1;
                grant_id = scan_idx[IDW-1:0];
            end
        end
        if (found) begin
            grant[grant_id] = 1'b1;
        end
    end

    always_comb begin
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                add_a_d = req_a_i[i*W +: W];
                add_b_d = req_b_i[i*W +: W];
            end
        end
        if (accept) begin
            rr_ptr_d = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            out_cnt_d[i] = out_cnt_q[i];
            if (grant[i] && !resp_hit[i]) begin
                out_cnt_d[i] = out_cnt_q[i] + CW'(1);
            end else if (!grant[i] && resp_hit[i]) begin
                out_cnt_d[i] = out_cnt_q[i] - CW'(1);
            end
        end
    end

    // DRAIN finishes when the last valid tag is in the final stage, so flush_done lands the cycle after the last response.
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req_i) begin
                    flush_done_d = 1'b1;
                end else if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush_req_i) begin
                    state_d = DRAIN;
                end else if (!accept && pipe_empty) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (pipe_drains) begin
                    flush_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            flush_done_q <= 1'b0;
            tag_vld_q    <= '0;
            for (int i = 0; i < N; i++) begin
                out_cnt_q[i] <= '0;
            end
            for (int s = 0; s <= LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            flush_done_q <= flush_done_d;
            tag_vld_q    <= {tag_vld_q[LAT-1:0], accept};
            tag_id_q[0]  <= grant_id;
            for (int i = 0; i < N; i++) begin
                out_cnt_q[i] <= out_cnt_d[i];
            end
            for (int s = 1; s <= LAT; s++) begin
                tag_id_q[s] <= tag_id_q[s-1];
            end
        end
    end

    assign req_ready_o  = grant;
    assign add_a_o      = add_a_q;
    assign add_b_o      = add_b_q;
    assign resp_valid_o = resp_hit;
    assign resp_sum_o   = tag_vld_q[LAT] ? add_sum_i : '0;
    assign resp_cout_o  = tag_vld_q[LAT] & add_cout_i;
    assign resp_id_o    = tag_vld_q[LAT] ? tag_id_q[LAT] : '0;
    assign flush_done_o = flush_done_q;
    assign busy_o       = (state_q != IDLE) || !pipe_empty;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler with a two-stage adder model and a response scoreboard.
module tb_adder_rr_scheduler;

    localparam int N       = 4;
    localparam int W       = 128;
    localparam int LAT     = 2;
    localparam int MAX_OUT = 2;
    localparam int IDW     = $clog2(N);

    typedef struct {
        logic [IDW-1:0] id;
        logic [W:0]     sum;
        int             cyc;
    } sbEntry_t;

    logic           clk = 1'b0;
    logic           rstN = 1'b0;
    logic [N-1:0]   reqValid, reqReady, respValid;
    logic [N*W-1:0] reqA, reqB;
    logic [W-1:0]   addA, addB, addSum, respSum;
    logic           addCout, respCout, flushReq, flushDone, busy;
    logic [IDW-1:0] respId;
    logic [W-1:0]   opA [N];
    logic [W-1:0]   opB [N];
    logic [W-1:0]   pendA [N];
    logic [W-1:0]   pendB [N];
    logic [W:0]     adderS1, adderS2;
    sbEntry_t       sb[$];
    sbEntry_t       mon;
    logic [N-1:0]   expOh;
    int             cycle = 0;
    int             checks = 0;
    int             passes = 0;
    int             fails = 0;

    always #5 clk = ~clk;

    adder_rr_scheduler #(.N(N), .W(W), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .req_a_i      (reqA),
        .req_b_i      (reqB),
        .add_a_o      (addA),
        .add_b_o      (addB),
        .add_sum_i    (addSum),
        .add_cout_i   (addCout),
        .resp_valid_o (respValid),
        .resp_sum_o   (respSum),
        .resp_cout_o  (respCout),
        .resp_id_o    (respId),
        .flush_req_i  (flushReq),
        .flush_done_o (flushDone),
        .busy_o       (busy)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            reqA[i*W +: W] = opA[i];
            reqB[i*W +: W] = opB[i];
        end
    end

    // Shared adder: LAT=2 unreset register stages, as the real macro would be.
    always @(posedge clk) begin
        adderS1 <= {1'b0, addA} + {1'b0, addB};
        adderS2 <= adderS1;
        cycle   <= cycle + 1;
    end
    assign addSum  = adderS2[W-1:0];
    assign addCout = adderS2[W];

    task automatic checkOutput(input string tag, input logic [W+7:0] obs, input logic [W+7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [N-1:0] valid, input logic flush,
                                 input logic [N-1:0] expReady);
        sbEntry_t e;
        @(posedge clk);
        #1;
        opA      = pendA;
        opB      = pendB;
        reqValid = valid;
        flushReq = flush;
        @(negedge clk);
        checkOutput(tag, reqReady, expReady);
        for (int i = 0; i < N; i++) begin
            if (expReady[i]) begin
                e.id  = IDW'(i);
                e.sum = {1'b0, opA[i]} + {1'b0, opB[i]};
                e.cyc = cycle;
                sb.push_back(e);
            end
        end
    endtask

    task automatic idleCycles(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            applyStimulus(tag, '0, 1'b0, '0);
        end
    endtask

    // Whatever was in flight is discarded by reset, so the scoreboard is emptied with it.
    task automatic doReset();
        @(posedge clk);
        #1;
        rstN     = 1'b0;
        reqValid = '0;
        flushReq = 1'b0;
        sb.delete();
        @(negedge clk);
        checkOutput("rst_ready", reqReady, '0);
        checkOutput("rst_add_a", addA, '0);
        checkOutput("rst_add_b", addB, '0);
        checkOutput("rst_resp_valid", respValid, '0);
        checkOutput("rst_resp_sum", respSum, '0);
        checkOutput("rst_resp_cout", respCout, '0);
        checkOutput("rst_resp_id", respId, '0);
        checkOutput("rst_flush_done", flushDone, '0);
        checkOutput("rst_busy", busy, '0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    always @(negedge clk) begin
        if (respValid !== '0) begin
            if (sb.size() == 0) begin
                checkOutput("resp_unexpected", respValid, '0);
            end else begin
                mon = sb.pop_front();
                expOh = '0;
                expOh[mon.id] = 1'b1;
                checkOutput("resp_valid", respValid, expOh);
                checkOutput("resp_id", respId, mon.id);
                checkOutput("resp_sum", respSum, mon.sum[W-1:0]);
                checkOutput("resp_cout", respCout, mon.sum[W]);
                checkOutput("resp_latency", cycle - mon.cyc, LAT + 1);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("%0d/%0d checks passed", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] t3Exp [7];
        t3Exp = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0100};
        reqValid = '0;
        flushReq = 1'b0;
        for (int i = 0; i < N; i++) begin
            opA[i]   = '0;
            opB[i]   = '0;
            pendA[i] = '0;
            pendB[i] = '0;
        end

        // Single op with full carry-out.
        doReset();
        pendA[0] = '1;
        pendB[0] = W'(1);
        applyStimulus("t1_grant", 4'b0001, 1'b0, 4'b0001);
        applyStimulus("t1_idle", '0, 1'b0, '0);
        checkOutput("t1_add_a", addA, {W{1'b1}});
        checkOutput("t1_add_b", addB, W'(1));
        idleCycles("t1_idle", 4);
        checkOutput("t1_busy", busy, 1'b0);
        checkOutput("t1_sb_empty", sb.size(), 0);

        // All four requesting: strict rotation, one grant per cycle.
        doReset();
        for (int i = 0; i < N; i++) begin
            pendA[i] = W'(i);
            pendB[i] = W'(100);
        end
        for (int c = 0; c < 8; c++) begin
            applyStimulus("t2_grant", '1, 1'b0, N'(1) << (c % N));
        end
        idleCycles("t2_idle", 4);
        checkOutput("t2_sb_empty", sb.size(), 0);

        // Lone requester throttled by its outstanding cap.
        doReset();
        for (int c = 0; c < 7; c++) begin
            pendA[2] = W'(c + 1);
            pendB[2] = W'(1000);
            applyStimulus("t3_grant", 4'b0100, 1'b0, t3Exp[c]);
        end
        idleCycles("t3_idle", 4);
        checkOutput("t3_sb_empty", sb.size(), 0);

        // Flush with three ops in flight.
        doReset();
        for (int i = 0; i < N; i++) begin
            pendA[i] = W'(10 * i + 1);
            pendB[i] = W'(2);
        end
        applyStimulus("t4_grant0", 4'b0111, 1'b0, 4'b0001);
        applyStimulus("t4_grant1", 4'b0111, 1'b0, 4'b0010);
        applyStimulus("t4_grant2", 4'b0111, 1'b0, 4'b0100);
        for (int c = 0; c < 3; c++) begin
            applyStimulus("t4_blocked", 4'b0111, 1'b1, '0);
            checkOutput("t4_done_low", flushDone, 1'b0);
            checkOutput("t4_busy_high", busy, 1'b1);
        end
        applyStimulus("t4_after", '0, 1'b0, '0);
        checkOutput("t4_done_pulse", flushDone, 1'b1);
        checkOutput("t4_busy_low", busy, 1'b0);
        checkOutput("t4_sb_empty", sb.size(), 0);
        applyStimulus("t4_after", '0, 1'b0, '0);
        checkOutput("t4_done_end", flushDone, 1'b0);

        // Reset with two ops in flight: nothing may come back.
        doReset();
        pendA[0] = W'(5);
        pendB[0] = W'(6);
        pendA[1] = W'(7);
        pendB[1] = W'(8);
        applyStimulus("t5_grant0", 4'b0011, 1'b0, 4'b0001);
        applyStimulus("t5_grant1", 4'b0011, 1'b0, 4'b0010);
        doReset();
        idleCycles("t5_quiet", 5);
        pendA[1] = W'(77);
        pendB[1] = W'(23);
        applyStimulus("t5_regrant", 4'b0010, 1'b0, 4'b0010);
        idleCycles("t5_idle", 4);
        checkOutput("t5_sb_empty", sb.size(), 0);

        // Flush while idle, held for two cycles so flush_done repeats.
        applyStimulus("t6_block0", '1, 1'b1, '0);
        checkOutput("t6_done0", flushDone, 1'b0);
        applyStimulus("t6_block1", '1, 1'b1, '0);
        checkOutput("t6_done1", flushDone, 1'b1);
        checkOutput("t6_busy1", busy, 1'b0);
        applyStimulus("t6_release", '0, 1'b0, '0);
        checkOutput("t6_done2", flushDone, 1'b1);
        applyStimulus("t6_quiet", '0, 1'b0, '0);
        checkOutput("t6_done3", flushDone, 1'b0);

        idleCycles("final_idle", 2);
        checkOutput("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
